// File: rtl/lsu_rmw.sv
// rtl/lsu_rmw.sv - load/store unit with sub-word extract, sign-extend and read-modify-write stores
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_rmw #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int ALIGN_FAULT = 0,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_fn,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic [XLEN-1:0]   bus_rdata,
  input  logic              bus_ack,
  output logic              busy
);
  localparam int NB = XLEN / 8;
  localparam int LB = $clog2(NB);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        fn_q, fn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] req_mask, req_eff;
  logic              req_err, req_full;
  logic [LB-1:0]     lane;
  logic [6:0]        fbits;
  logic [XLEN-1:0]   ones, rd_shl, ld_val, lane_mask, wd_pos, st_merge;
  logic              tmo;

  assign req_mask = ADDR_W'((4'd1 << req_fn[1:0]) - 4'd1);
  assign req_eff  = req_addr & ~req_mask;
  assign req_full = (req_fn[1:0] == 2'(LB));
  assign req_err  = (req_fn[1:0] == 2'd3 && XLEN == 32) ||
                    (ALIGN_FAULT != 0 && (req_addr & req_mask) != '0);

  // Big-endian lanes: shifting left by the lane puts the addressed field at the MSB end.
  assign lane      = addr_q[LB-1:0];
  assign fbits     = 7'd8 << fn_q[1:0];
  assign ones      = '1;
  assign rd_shl    = bus_rdata << {lane, 3'b000};
  assign lane_mask = ~(ones >> fbits) >> {lane, 3'b000};
  assign wd_pos    = (wdata_q << (7'(XLEN) - fbits)) >> {lane, 3'b000};
  assign st_merge  = (bus_rdata & ~lane_mask) | (wd_pos & lane_mask);

  always_comb begin
    ld_val = rd_shl >> (7'(XLEN) - fbits);
    if (fn_q[2]) ld_val = $signed(rd_shl) >>> (7'(XLEN) - fbits);
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (bus_req && !bus_ack) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tmo = bus_req && !bus_ack && (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    fn_d    = fn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          fn_d    = req_fn;
          addr_d  = req_eff;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = req_err;
          if (req_err)               state_d = RESP;
          else if (req_we && req_full) state_d = WR;
          else                       state_d = RD;
        end
      end
      RD: begin
        if (tmo) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else if (bus_ack) begin
          if (we_q) begin
            wdata_d = st_merge;
            state_d = WR;
          end else begin
            rdata_d = ld_val;
            state_d = RESP;
          end
        end
      end
      WR: begin
        if (tmo) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (bus_ack) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      fn_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      fn_q    <= fn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid & err_q;
  assign bus_req    = (state_q == RD) || (state_q == WR);
  assign bus_we     = (state_q == WR);
  assign bus_addr   = bus_req ? (addr_q & ~ADDR_W'(NB - 1)) : '0;
  assign bus_wdata  = bus_we ? wdata_q : '0;
endmodule

// File: tb/tb_lsu_rmw.sv
// tb/tb_lsu_rmw.sv - self-checking bench for lsu_rmw against a byte-array reference model
module tb_lsu_rmw;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        a_req_valid, a_req_we, a_bus_ack;
  logic [2:0]  a_req_fn;
  logic [31:0] a_req_addr, a_req_wdata, a_bus_rdata;
  logic        a_req_ready, a_resp_valid, a_resp_err, a_bus_req, a_bus_we, a_busy;
  logic [31:0] a_resp_rdata, a_bus_addr, a_bus_wdata;

  logic        b_req_valid, b_req_we, b_bus_ack;
  logic [2:0]  b_req_fn;
  logic [31:0] b_req_addr;
  logic [63:0] b_req_wdata, b_bus_rdata;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_bus_req, b_bus_we, b_busy;
  logic [31:0] b_bus_addr;
  logic [63:0] b_resp_rdata, b_bus_wdata;

  lsu_rmw #(.XLEN(32), .ADDR_W(32), .ALIGN_FAULT(0), .TIMEOUT_CYC(8)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_fn(a_req_fn), .req_addr(a_req_addr), .req_wdata(a_req_wdata), .resp_valid(a_resp_valid),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .bus_req(a_bus_req), .bus_we(a_bus_we),
    .bus_addr(a_bus_addr), .bus_wdata(a_bus_wdata), .bus_rdata(a_bus_rdata), .bus_ack(a_bus_ack),
    .busy(a_busy));

  lsu_rmw #(.XLEN(64), .ADDR_W(32), .ALIGN_FAULT(1), .TIMEOUT_CYC(8)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_fn(b_req_fn), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .resp_valid(b_resp_valid),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .bus_req(b_bus_req), .bus_we(b_bus_we),
    .bus_addr(b_bus_addr), .bus_wdata(b_bus_wdata), .bus_rdata(b_bus_rdata), .bus_ack(b_bus_ack),
    .busy(b_busy));

  // Observations of the last access
  bit          r_got, r_err, r_stable, r_pulse_ok;
  int          r_lat, r_nrd, r_nwr;
  logic [63:0] r_rdata, r_wdata;
  logic [31:0] r_raddr, r_waddr;

  function automatic bit ref_err(input int nb, input bit af, input logic [2:0] fn, input logic [31:0] addr);
    int n;
    n = 1 << fn[1:0];
    return (fn[1:0] == 2'd3 && nb == 4) || (af && (addr % 32'(n)) != 32'd0);
  endfunction

  function automatic logic [31:0] ref_baddr(input int nb, input logic [2:0] fn, input logic [31:0] addr);
    logic [31:0] eff;
    eff = addr - addr % (32'd1 << fn[1:0]);
    return eff - eff % 32'(nb);
  endfunction

  function automatic logic [63:0] ref_load(input int nb, input logic [2:0] fn, input logic [31:0] addr,
                                           input logic [63:0] word);
    int n, lane;
    logic [63:0] v;
    n    = 1 << fn[1:0];
    lane = int'((addr - addr % 32'(n)) % 32'(nb));
    v    = '0;
    for (int i = 0; i < n; i++) v = {v[55:0], word[8*nb-1-8*(lane+i) -: 8]};
    if (fn[2] && n < nb && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    if (nb == 4) v[63:32] = '0;
    return v;
  endfunction

  function automatic logic [63:0] ref_merge(input int nb, input logic [2:0] fn, input logic [31:0] addr,
                                            input logic [63:0] word, input logic [63:0] wdata);
    int n, lane;
    logic [63:0] v;
    n    = 1 << fn[1:0];
    lane = int'((addr - addr % 32'(n)) % 32'(nb));
    v    = word;
    for (int i = 0; i < n; i++) v[8*nb-1-8*(lane+i) -: 8] = wdata[8*(n-1-i) +: 8];
    return v;
  endfunction

  // Drives one request into DUT a (sel=0) or b (sel=1) and plays the bus slave with dly wait cycles per phase.
  task automatic do_access(input bit sel, input logic we, input logic [2:0] fn, input logic [31:0] addr,
                           input logic [63:0] wdata, input logic [63:0] rword, input int dly);
    int cyc, w;
    logic v, e, br, bw, ack;
    logic [63:0] d, bd, pd;
    logic [31:0] ba, pa;
    r_got = 0; r_err = 0; r_stable = 1; r_pulse_ok = 0; r_lat = 0; r_nrd = 0; r_nwr = 0;
    r_rdata = '0; r_wdata = '0; r_raddr = '0; r_waddr = '0;
    pa = '0; pd = '0; w = 0; cyc = 1;
    if (sel) begin
      b_req_valid = 1; b_req_we = we; b_req_fn = fn; b_req_addr = addr; b_req_wdata = wdata;
    end else begin
      a_req_valid = 1; a_req_we = we; a_req_fn = fn; a_req_addr = addr; a_req_wdata = wdata[31:0];
    end
    while (!r_got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin
        a_req_valid = 0; b_req_valid = 0;
        a_req_addr = $urandom; b_req_addr = $urandom;
        a_req_wdata = $urandom; b_req_wdata = {$urandom, $urandom};
        a_req_fn = 3'($urandom_range(0, 7)); b_req_fn = 3'($urandom_range(0, 7));
      end
      if (sel) begin
        v = b_resp_valid; e = b_resp_err; d = b_resp_rdata; br = b_bus_req; bw = b_bus_we;
        ba = b_bus_addr; bd = b_bus_wdata;
      end else begin
        v = a_resp_valid; e = a_resp_err; d = {32'h0, a_resp_rdata}; br = a_bus_req; bw = a_bus_we;
        ba = a_bus_addr; bd = {32'h0, a_bus_wdata};
      end
      ack = 0;
      if (v) begin
        r_got = 1; r_lat = cyc; r_err = e; r_rdata = d;
      end else if (br) begin
        if (w == 0) begin pa = ba; pd = bd; end
        else if (ba !== pa || bd !== pd) r_stable = 0;
        if (w >= dly) begin
          ack = 1; w = 0;
          if (bw) begin r_nwr++; r_waddr = ba; r_wdata = bd; end
          else begin r_nrd++; r_raddr = ba; end
        end else w++;
      end
      if (sel) begin b_bus_ack = ack; b_bus_rdata = ack ? rword : {$urandom, $urandom}; end
      else begin a_bus_ack = ack; a_bus_rdata = ack ? rword[31:0] : $urandom; end
    end
    a_bus_ack = 0; b_bus_ack = 0;
    @(negedge clk);
    if (sel) r_pulse_ok = !b_resp_valid && b_req_ready;
    else     r_pulse_ok = !a_resp_valid && a_req_ready;
  endtask

  task automatic test_reset;
    rst = 1;
    a_req_valid = 0; a_req_we = 0; a_req_fn = '0; a_req_addr = '0; a_req_wdata = '0;
    a_bus_ack = 0; a_bus_rdata = '0;
    b_req_valid = 0; b_req_we = 0; b_req_fn = '0; b_req_addr = '0; b_req_wdata = '0;
    b_bus_ack = 0; b_bus_rdata = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({a_req_ready, a_resp_valid, a_resp_err, a_bus_req, a_bus_we, a_busy, a_resp_rdata, a_bus_addr, a_bus_wdata}
          !== {1'b1, 5'b0, 96'h0}) begin
        bad++;
        $display("FAIL reset_a[%0d]: got rdy=%b rv=%b err=%b breq=%b bwe=%b busy=%b rd=%h ba=%h bwd=%h, want rdy=1 others 0",
                 k, a_req_ready, a_resp_valid, a_resp_err, a_bus_req, a_bus_we, a_busy, a_resp_rdata, a_bus_addr, a_bus_wdata);
      end
      total++;
      if ({b_req_ready, b_resp_valid, b_resp_err, b_bus_req, b_bus_we, b_busy, b_resp_rdata, b_bus_addr, b_bus_wdata}
          !== {1'b1, 5'b0, 160'h0}) begin
        bad++;
        $display("FAIL reset_b[%0d]: got rdy=%b rv=%b breq=%b busy=%b rd=%h ba=%h bwd=%h, want rdy=1 others 0",
                 k, b_req_ready, b_resp_valid, b_bus_req, b_busy, b_resp_rdata, b_bus_addr, b_bus_wdata);
      end
      rst = 0;
      @(negedge clk);
    end
  endtask

  task automatic test_directed;
    do_access(0, 0, 3'b100, 32'h102, 64'h0, 64'h11228344, 0);
    total++;
    if ({r_got, r_err, r_rdata, r_raddr, r_nrd, r_nwr, r_lat} !== {2'b10, 64'hFFFFFF83, 32'h100, 32'd1, 32'd0, 32'd3}) begin
      bad++;
      $display("FAIL sbyte_load: got got=%b err=%b rd=%h ba=%h nrd=%0d nwr=%0d lat=%0d, want 1 0 ffffff83 100 1 0 3",
               r_got, r_err, r_rdata, r_raddr, r_nrd, r_nwr, r_lat);
    end
    do_access(0, 1, 3'b000, 32'h101, 64'hAB, 64'h11223344, 0);
    total++;
    if ({r_got, r_err, r_rdata, r_raddr, r_waddr, r_wdata, r_nrd, r_nwr, r_lat}
        !== {2'b10, 64'h0, 32'h100, 32'h100, 64'h11AB3344, 32'd1, 32'd1, 32'd4}) begin
      bad++;
      $display("FAIL byte_store: got got=%b err=%b rd=%h ra=%h wa=%h wd=%h nrd=%0d nwr=%0d lat=%0d, want rd=0 wa=100 wd=11ab3344 lat=4",
               r_got, r_err, r_rdata, r_raddr, r_waddr, r_wdata, r_nrd, r_nwr, r_lat);
    end
    do_access(0, 0, 3'b001, 32'h102, 64'h0, 64'h1122F344, 0);
    total++;
    if ({r_got, r_err, r_rdata} !== {2'b10, 64'h0000F344}) begin
      bad++;
      $display("FAIL uhalf_load: got got=%b err=%b rd=%h, want 1 0 0000f344", r_got, r_err, r_rdata);
    end
    do_access(0, 0, 3'b101, 32'h102, 64'h0, 64'h1122F344, 0);
    total++;
    if ({r_got, r_err, r_rdata} !== {2'b10, 64'hFFFFF344}) begin
      bad++;
      $display("FAIL shalf_load: got got=%b err=%b rd=%h, want 1 0 fffff344", r_got, r_err, r_rdata);
    end
    do_access(1, 0, 3'b010, 32'h103, 64'h0, 64'h0123456789ABCDEF, 0);
    total++;
    if ({r_got, r_err, r_rdata, r_nrd, r_nwr, r_lat} !== {2'b11, 64'h0, 32'd0, 32'd0, 32'd2}) begin
      bad++;
      $display("FAIL align_fault: got got=%b err=%b rd=%h nrd=%0d nwr=%0d lat=%0d, want 1 1 0 0 0 2",
               r_got, r_err, r_rdata, r_nrd, r_nwr, r_lat);
    end
    do_access(0, 0, 3'b010, 32'h103, 64'h0, 64'hCAFEF00D, 0);
    total++;
    if ({r_got, r_err, r_rdata, r_raddr} !== {2'b10, 64'hCAFEF00D, 32'h100}) begin
      bad++;
      $display("FAIL align_clear: got got=%b err=%b rd=%h ba=%h, want 1 0 cafef00d 100", r_got, r_err, r_rdata, r_raddr);
    end
    do_access(0, 0, 3'b011, 32'h8, 64'h0, 64'h0, 0);
    total++;
    if ({r_got, r_err, r_nrd, r_lat} !== {2'b11, 32'd0, 32'd2}) begin
      bad++;
      $display("FAIL dword_on_32: got got=%b err=%b nrd=%0d lat=%0d, want 1 1 0 2", r_got, r_err, r_nrd, r_lat);
    end
    do_access(1, 0, 3'b011, 32'h8, 64'h0, 64'h0123456789ABCDEF, 0);
    total++;
    if ({r_got, r_err, r_rdata, r_raddr, r_nrd, r_nwr, r_lat}
        !== {2'b10, 64'h0123456789ABCDEF, 32'h8, 32'd1, 32'd0, 32'd3}) begin
      bad++;
      $display("FAIL dword_load_64: got got=%b err=%b rd=%h ba=%h nrd=%0d nwr=%0d lat=%0d, want rd=0123456789abcdef ba=8 1 0 3",
               r_got, r_err, r_rdata, r_raddr, r_nrd, r_nwr, r_lat);
    end
  endtask

  task automatic test_random(input bit sel, input int count);
    int nb, n, exp_nrd, exp_nwr, exp_lat, dly;
    bit e, full, we;
    logic [2:0] fn;
    logic [31:0] addr, ba;
    logic [63:0] mask, wdata, rword, exp_rd, exp_wd;
    nb   = sel ? 8 : 4;
    mask = sel ? '1 : 64'hFFFF_FFFF;
    for (int t = 0; t < count; t++) begin
      we    = 1'($urandom_range(0, 1));
      fn    = 3'($urandom_range(0, 7));
      addr  = $urandom;
      wdata = {$urandom, $urandom} & mask;
      rword = {$urandom, $urandom} & mask;
      dly   = $urandom_range(0, 2);
      do_access(sel, we, fn, addr, wdata, rword, dly);
      n       = 1 << fn[1:0];
      e       = ref_err(nb, sel, fn, addr);
      full    = (n == nb);
      exp_nrd = (e || (we && full)) ? 0 : 1;
      exp_nwr = (!e && we) ? 1 : 0;
      exp_lat = 2 + (exp_nrd + exp_nwr) * (dly + 1);
      exp_rd  = (e || we) ? 64'h0 : ref_load(nb, fn, addr, rword);
      exp_wd  = full ? wdata : ref_merge(nb, fn, addr, rword, wdata);
      ba      = ref_baddr(nb, fn, addr);
      total++;
      if ({r_got, r_err, r_rdata, r_lat} !== {1'b1, e, exp_rd, exp_lat}) begin
        bad++;
        $display("FAIL rand_resp[%0d.%0d] we=%b fn=%b addr=%h: got got=%b err=%b rd=%h lat=%0d, want err=%b rd=%h lat=%0d",
                 sel, t, we, fn, addr, r_got, r_err, r_rdata, r_lat, e, exp_rd, exp_lat);
      end
      total++;
      if ({r_nrd, r_nwr} !== {exp_nrd, exp_nwr}) begin
        bad++;
        $display("FAIL rand_bus_count[%0d.%0d]: got nrd=%0d nwr=%0d, want nrd=%0d nwr=%0d",
                 sel, t, r_nrd, r_nwr, exp_nrd, exp_nwr);
      end
      if (r_nrd > 0) begin
        total++;
        if (r_raddr !== ba) begin
          bad++;
          $display("FAIL rand_raddr[%0d.%0d]: got %h, want %h", sel, t, r_raddr, ba);
        end
      end
      if (r_nwr > 0) begin
        total++;
        if ({r_waddr, r_wdata} !== {ba, exp_wd}) begin
          bad++;
          $display("FAIL rand_write[%0d.%0d]: got wa=%h wd=%h, want wa=%h wd=%h", sel, t, r_waddr, r_wdata, ba, exp_wd);
        end
      end
      total++;
      if ({r_stable, r_pulse_ok} !== 2'b11) begin
        bad++;
        $display("FAIL rand_stable_pulse[%0d.%0d]: got stable=%b pulse_ok=%b, want 1 1", sel, t, r_stable, r_pulse_ok);
      end
    end
  endtask

  task automatic test_ack_ignored;
    a_bus_ack = 1; a_bus_rdata = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    total++;
    if ({a_busy, a_resp_valid, a_bus_req, a_req_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL ack_idle: got busy=%b rv=%b breq=%b rdy=%b, want 0 0 0 1", a_busy, a_resp_valid, a_bus_req, a_req_ready);
    end
    a_bus_ack = 0;
  endtask

  task automatic test_reset_mid;
    bit seen;
    a_req_valid = 1; a_req_we = 0; a_req_fn = 3'b010; a_req_addr = 32'h200; a_bus_ack = 0;
    @(negedge clk);
    a_req_valid = 0;
    @(negedge clk);
    total++;
    if (a_bus_req !== 1'b1) begin
      bad++;
      $display("FAIL mid_rd_active: got bus_req=%b, want 1", a_bus_req);
    end
    rst = 1;
    #1;
    total++;
    if ({a_bus_req, a_busy, a_resp_valid, a_req_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL mid_reset_async: got breq=%b busy=%b rv=%b rdy=%b, want 0 0 0 1",
               a_bus_req, a_busy, a_resp_valid, a_req_ready);
    end
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_resp_valid || !a_req_ready) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL mid_reset_noresp: got spurious response or not ready = %b, want 0", seen);
    end
    do_access(0, 0, 3'b000, 32'h203, 64'h0, 64'h000000C5, 0);
    total++;
    if ({r_got, r_err, r_rdata} !== {2'b10, 64'hC5}) begin
      bad++;
      $display("FAIL mid_reset_after: got got=%b err=%b rd=%h, want 1 0 c5", r_got, r_err, r_rdata);
    end
  endtask

  task automatic test_timeout;
    int hi, cyc;
    bit got, err, saw_we;
    logic [31:0] rd;
    for (int k = 0; k < 2; k++) begin
      a_req_valid = 1; a_req_we = (k == 1); a_req_fn = 3'b000; a_req_addr = 32'h301; a_req_wdata = 32'h5A;
      a_bus_ack = 0;
      hi = 0; cyc = 0; got = 0; err = 0; saw_we = 0; rd = '1;
      @(negedge clk);
      a_req_valid = 0;
`ifdef LSU_TIMEOUT_EN
      while (!got && cyc < 40) begin
        if (a_resp_valid) begin got = 1; err = a_resp_err; rd = a_resp_rdata; end
        if (a_bus_req) hi++;
        if (a_bus_we) saw_we = 1;
        @(negedge clk);
        cyc++;
      end
      total++;
      if ({got, err, rd, hi, saw_we} !== {2'b11, 32'h0, 32'd8, 1'b0}) begin
        bad++;
        $display("FAIL timeout[%0d]: got got=%b err=%b rd=%h req_cycles=%0d saw_we=%b, want 1 1 0 8 0",
                 k, got, err, rd, hi, saw_we);
      end
`else
      while (cyc < 20) begin
        if (a_resp_valid) got = 1;
        if (a_bus_req) hi++;
        @(negedge clk);
        cyc++;
      end
      a_bus_ack = 1; a_bus_rdata = 32'h00AA0000;
      @(negedge clk);
      a_bus_ack = 0;
      if (k == 1) begin
        a_bus_ack = 1;
        @(negedge clk);
        a_bus_ack = 0;
      end
      err = a_resp_err; rd = a_resp_rdata;
      total++;
      if ({got, hi, a_resp_valid, err, rd} !== {1'b0, 32'd20, 2'b10, (k == 1) ? 32'h0 : 32'hAA}) begin
        bad++;
        $display("FAIL wait_forever[%0d]: got early=%b req_cycles=%0d rv=%b err=%b rd=%h, want 0 20 1 0 %h",
                 k, got, hi, a_resp_valid, err, rd, (k == 1) ? 32'h0 : 32'hAA);
      end
      @(negedge clk);
`endif
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ack_ignored();
    test_random(0, 40);
    test_random(1, 40);
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
